// File: rtl/matmul_sequencer.sv
// Sequences one systolic-array matrix multiply: weight load, then skewed per-lane input reads and output writes.
// Latency: start -> (LOAD_W, WAIT_W unless skipped) -> ARRAY_LAT+2*W-1 COMPUTE cycles -> 1-cycle DONE pulse.
// Backpressure: none on the lane buses; waits only on fifo_done_i, and start_i is taken only in IDLE.
module matmul_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ARRAY_LAT    = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      skip_weights_i,
    input  logic [7:0]                in_base_i,
    input  logic [7:0]                out_base_i,
    input  logic                      fifo_done_i,
    output logic                      fifo_start_o,
    output logic                      sys_active_o,
    output logic [WIDTH_HEIGHT-1:0]   in_rd_en_o,
    output logic [WIDTH_HEIGHT*8-1:0] in_rd_addr_o,
    output logic [WIDTH_HEIGHT-1:0]   out_wr_en_o,
    output logic [WIDTH_HEIGHT*8-1:0] out_wr_addr_o,
    output logic                      busy_o,
    output logic                      done_o
);

    // Final COMPUTE count: the last output lane finishes its W-row burst here.
    localparam int LAST = ARRAY_LAT + 2 * WIDTH_HEIGHT - 2;
    localparam int CW   = $clog2(LAST + 1);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_WAIT_W  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    in_base_q, in_base_d;
    logic [7:0]    out_base_q, out_base_d;

    // State, cycle counter and latched base addresses; reset aborts any run in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
        end
    end

    // Next-state logic; cnt is only non-zero inside COMPUTE so every run starts from 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    in_base_d  = in_base_i;
                    out_base_d = out_base_i;
                    state_d    = skip_weights_i ? ST_COMPUTE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                state_d = ST_WAIT_W;
            end
            ST_WAIT_W: begin
                if (fifo_done_i) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == LAST_C) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode: lane i reads rows 0..W-1 skewed by i cycles; outputs trail by ARRAY_LAT.
    always_comb begin
        fifo_start_o  = (state_q == ST_LOAD_W);
        sys_active_o  = (state_q == ST_COMPUTE);
        busy_o        = (state_q == ST_LOAD_W) || (state_q == ST_WAIT_W) || (state_q == ST_COMPUTE);
        done_o        = (state_q == ST_DONE);
        in_rd_en_o    = '0;
        in_rd_addr_o  = '0;
        out_wr_en_o   = '0;
        out_wr_addr_o = '0;
        if (state_q == ST_COMPUTE) begin
            for (int i = 0; i < WIDTH_HEIGHT; i++) begin
                if (int'(cnt_q) >= i && int'(cnt_q) <= i + WIDTH_HEIGHT - 1) begin
                    in_rd_en_o[i]         = 1'b1;
                    in_rd_addr_o[8*i +: 8] = in_base_q + 8'(int'(cnt_q) - i);
                end
                if (int'(cnt_q) >= ARRAY_LAT + i &&
                    int'(cnt_q) <= ARRAY_LAT + i + WIDTH_HEIGHT - 1) begin
                    out_wr_en_o[i]          = 1'b1;
                    out_wr_addr_o[8*i +: 8] = out_base_q + 8'(int'(cnt_q) - ARRAY_LAT - i);
                end
            end
        end
    end

endmodule
